// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous-read memory between instruction
// fetch and data load/store, data having fixed priority over fetch.
// Each access runs IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> RESP.
module mem_port_arbiter #(
  parameter int unsigned AW      = 6,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_ack_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_ack_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          owner_o,
  output logic [15:0]   fetch_stall_cnt_o
);

  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT);
  localparam logic [15:0]   STALL_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic            owner_q, owner_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            if_ack_q, if_ack_d;
  logic            d_ack_q, d_ack_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic [15:0]     stall_q, stall_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    owner_d     = owner_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (d_req_i) begin
          owner_d     = 1'b1;
          we_d        = d_we_i;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          state_d     = ACCESS;
        end else if (if_req_i) begin
          owner_d     = 1'b0;
          we_d        = 1'b0;
          mem_en_d    = 1'b1;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          if (!owner_q) begin
            if_rdata_d = mem_rdata_i;
            if_ack_d   = 1'b1;
          end else begin
            if (!we_q) d_rdata_d = mem_rdata_i;
            d_ack_d = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Fetch is waiting whenever it requests and is not being acknowledged.
    stall_d = stall_q;
    if (if_req_i && !if_ack_q && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      owner_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      stall_q     <= stall_d;
    end
  end

  assign if_ack_o          = if_ack_q;
  assign if_rdata_o        = if_rdata_q;
  assign d_ack_o           = d_ack_q;
  assign d_rdata_o         = d_rdata_q;
  assign mem_en_o          = mem_en_q;
  assign mem_we_o          = mem_we_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_wdata_o       = mem_wdata_q;
  assign owner_o           = owner_q;
  assign fetch_stall_cnt_o = stall_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), a
// transaction-level model checked every cycle, and directed literal checks.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        if_req [2];
  logic [5:0]  if_addr [2];
  logic        d_req [2];
  logic        d_we [2];
  logic [5:0]  d_addr [2];
  logic [31:0] d_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        if_ack [2];
  logic [31:0] if_rdata [2];
  logic        d_ack [2];
  logic [31:0] d_rdata [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [5:0]  mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic        owner [2];
  logic [15:0] stall [2];

  mem_port_arbiter #(.AW(6), .DW(32), .MEM_LAT(1)) u0 (
    .clk(clk), .rst(rst),
    .if_req_i(if_req[0]), .if_addr_i(if_addr[0]), .if_ack_o(if_ack[0]), .if_rdata_o(if_rdata[0]),
    .d_req_i(d_req[0]), .d_we_i(d_we[0]), .d_addr_i(d_addr[0]), .d_wdata_i(d_wdata[0]),
    .d_ack_o(d_ack[0]), .d_rdata_o(d_rdata[0]),
    .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0]),
    .owner_o(owner[0]), .fetch_stall_cnt_o(stall[0]));

  mem_port_arbiter #(.AW(6), .DW(32), .MEM_LAT(3)) u1 (
    .clk(clk), .rst(rst),
    .if_req_i(if_req[1]), .if_addr_i(if_addr[1]), .if_ack_o(if_ack[1]), .if_rdata_o(if_rdata[1]),
    .d_req_i(d_req[1]), .d_we_i(d_we[1]), .d_addr_i(d_addr[1]), .d_wdata_i(d_wdata[1]),
    .d_ack_o(d_ack[1]), .d_rdata_o(d_rdata[1]),
    .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1]),
    .owner_o(owner[1]), .fetch_stall_cnt_o(stall[1]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", nm, k, cyc, act, exp);
    end
  endtask

  // Memory environment state and memory contents (environment + model copy).
  logic [31:0] mem_arr [2][64];
  logic [31:0] model_mem [2][64];
  logic        en_valid [2];
  int          en_cyc [2];
  logic [31:0] en_data [2];

  // Transaction-level model state.
  logic        m_act [2];
  int          m_g [2];
  logic        m_d [2];
  logic        m_we [2];
  logic [5:0]  m_addr [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_data [2];
  logic [31:0] e_ird [2];
  logic [31:0] e_drd [2];
  logic        e_own [2];
  logic [15:0] e_stall [2];
  logic        me_en, me_ack;
  int          ml;

  // Memory read data: valid only in the cycle MEM_LAT after the strobe.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (en_valid[k] && (cyc == en_cyc[k] + lat_of(k)))
        mem_rdata[k] = en_data[k];
      else
        mem_rdata[k] = 32'hBAD0_0000 | (32'(cyc) & 32'h0000_FFFF);
    end
  end

  // Per-cycle compare against the model, then advance model and memory.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_act[k] = 1'b0; e_ird[k] = '0; e_drd[k] = '0; e_own[k] = 1'b0;
        e_stall[k] = '0; en_valid[k] = 1'b0;
        chk("rst_mem_en", k, mem_en[k], 0);
        chk("rst_mem_we", k, mem_we[k], 0);
        chk("rst_mem_addr", k, mem_addr[k], 0);
        chk("rst_mem_wdata", k, mem_wdata[k], 0);
        chk("rst_if_ack", k, if_ack[k], 0);
        chk("rst_d_ack", k, d_ack[k], 0);
        chk("rst_if_rdata", k, if_rdata[k], 0);
        chk("rst_d_rdata", k, d_rdata[k], 0);
        chk("rst_owner", k, owner[k], 0);
        chk("rst_stall", k, stall[k], 0);
      end else begin
        ml     = lat_of(k);
        me_en  = m_act[k] && (cyc == m_g[k] + 1);
        me_ack = m_act[k] && (cyc == m_g[k] + ml + 2);
        if (me_en) e_own[k] = m_d[k];
        if (me_ack) begin
          if (!m_d[k]) e_ird[k] = m_data[k];
          else if (!m_we[k]) e_drd[k] = m_data[k];
        end
        chk("mem_en", k, mem_en[k], me_en);
        chk("mem_we", k, mem_we[k], me_en && m_we[k]);
        chk("if_ack", k, if_ack[k], me_ack && !m_d[k]);
        chk("d_ack", k, d_ack[k], me_ack && m_d[k]);
        chk("if_rdata", k, if_rdata[k], e_ird[k]);
        chk("d_rdata", k, d_rdata[k], e_drd[k]);
        chk("owner", k, owner[k], e_own[k]);
        chk("stall", k, stall[k], e_stall[k]);
        if (me_en) chk("mem_addr", k, mem_addr[k], m_addr[k]);
        if (me_en && m_we[k]) chk("mem_wdata", k, mem_wdata[k], m_wdata[k]);

        if (if_req[k] && !(me_ack && !m_d[k]) && (e_stall[k] != 16'hFFFF))
          e_stall[k] = e_stall[k] + 16'd1;
        if (me_ack) begin
          m_act[k] = 1'b0;
        end else if (!m_act[k] && (d_req[k] || if_req[k])) begin
          m_act[k]   = 1'b1;
          m_g[k]     = cyc;
          m_d[k]     = d_req[k];
          m_we[k]    = d_req[k] && d_we[k];
          m_addr[k]  = d_req[k] ? d_addr[k] : if_addr[k];
          m_wdata[k] = d_wdata[k];
          if (m_we[k]) model_mem[k][m_addr[k]] = m_wdata[k];
          m_data[k]  = model_mem[k][m_addr[k]];
        end

        if (mem_en[k]) begin
          en_valid[k] = 1'b1;
          en_cyc[k]   = cyc;
          en_data[k]  = mem_arr[k][mem_addr[k]];
          if (mem_we[k]) mem_arr[k][mem_addr[k]] = mem_wdata[k];
        end
      end
    end
  end

  task automatic drive_at(input int c);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < c);
  endtask

  task automatic at_neg(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  int c0;
  logic [15:0] base;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0; if_addr[k] = '0; d_req[k] = 0; d_we[k] = 0;
      d_addr[k] = '0; d_wdata[k] = '0; mem_rdata[k] = '0;
      for (int a = 0; a < 64; a++) mem_arr[k][a] = 32'h1000_0000 + 32'(k * 256 + a);
    end
    mem_arr[0][5] = 32'h00A0_0093;
    mem_arr[0][3] = 32'h0000_3333;
    mem_arr[0][7] = 32'h7777_0007;
    mem_arr[1][5] = 32'h1122_3344;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 64; a++) model_mem[k][a] = mem_arr[k][a];
    #22 rst = 1'b0;

    // Idle after reset: no strobe.
    at_neg(cyc + 3);
    chk("idle_mem_en", 0, mem_en[0], 0);
    chk("idle_mem_en", 1, mem_en[1], 0);

    // Single fetch, MEM_LAT=1.
    c0 = cyc + 2;
    drive_at(c0); if_req[0] = 1; if_addr[0] = 6'd5;
    at_neg(c0 + 1);
    chk("A_mem_en", 0, mem_en[0], 1);
    chk("A_mem_addr", 0, mem_addr[0], 5);
    chk("A_mem_we", 0, mem_we[0], 0);
    at_neg(c0 + 2); chk("A_ack_early", 0, if_ack[0], 0);
    at_neg(c0 + 3);
    chk("A_if_ack", 0, if_ack[0], 1);
    chk("A_if_rdata", 0, if_rdata[0], 32'h00A0_0093);
    chk("A_stall", 0, stall[0], 3);
    drive_at(c0 + 4); if_req[0] = 0;
    at_neg(c0 + 4); chk("A_ack_late", 0, if_ack[0], 0);

    // Conflict: data load wins, then fetch.
    base = stall[0];
    c0 = cyc + 2;
    drive_at(c0);
    if_req[0] = 1; if_addr[0] = 6'd7; d_req[0] = 1; d_we[0] = 0; d_addr[0] = 6'd3;
    at_neg(c0 + 1);
    chk("B_mem_addr_d", 0, mem_addr[0], 3);
    chk("B_owner1", 0, owner[0], 1);
    at_neg(c0 + 3);
    chk("B_d_ack", 0, d_ack[0], 1);
    chk("B_if_ack0", 0, if_ack[0], 0);
    chk("B_d_rdata", 0, d_rdata[0], 32'h0000_3333);
    drive_at(c0 + 4); d_req[0] = 0;
    at_neg(c0 + 4); chk("B_owner4", 0, owner[0], 1);
    at_neg(c0 + 5);
    chk("B_mem_en_f", 0, mem_en[0], 1);
    chk("B_mem_addr_f", 0, mem_addr[0], 7);
    chk("B_owner5", 0, owner[0], 0);
    at_neg(c0 + 7);
    chk("B_if_ack", 0, if_ack[0], 1);
    chk("B_if_rdata", 0, if_rdata[0], 32'h7777_0007);
    chk("B_stall", 0, stall[0], base + 16'd7);
    drive_at(c0 + 8); if_req[0] = 0;

    // Store: write strobe only in ACCESS, load data untouched.
    c0 = cyc + 2;
    drive_at(c0); d_req[0] = 1; d_we[0] = 1; d_addr[0] = 6'd10; d_wdata[0] = 32'hDEAD_BEEF;
    at_neg(c0 + 1);
    chk("C_mem_we", 0, mem_we[0], 1);
    chk("C_mem_wdata", 0, mem_wdata[0], 32'hDEAD_BEEF);
    chk("C_mem_addr", 0, mem_addr[0], 10);
    at_neg(c0 + 2); chk("C_mem_we_off", 0, mem_we[0], 0);
    at_neg(c0 + 3);
    chk("C_d_ack", 0, d_ack[0], 1);
    chk("C_d_rdata_keep", 0, d_rdata[0], 32'h0000_3333);
    drive_at(c0 + 4); d_req[0] = 0; d_we[0] = 0;

    // Load back the stored word.
    c0 = cyc + 2;
    drive_at(c0); d_req[0] = 1; d_addr[0] = 6'd10;
    at_neg(c0 + 3); chk("C2_d_rdata", 0, d_rdata[0], 32'hDEAD_BEEF);
    drive_at(c0 + 4); d_req[0] = 0;

    // Reset during WAIT of a fetch, then reissue.
    c0 = cyc + 2;
    drive_at(c0); if_req[0] = 1; if_addr[0] = 6'd5;
    at_neg(c0 + 2);
    #2; rst = 1'b1; if_req[0] = 0;
    #1;
    chk("D_mem_en", 0, mem_en[0], 0);
    chk("D_if_ack", 0, if_ack[0], 0);
    chk("D_if_rdata", 0, if_rdata[0], 0);
    chk("D_d_rdata", 0, d_rdata[0], 0);
    chk("D_owner", 0, owner[0], 0);
    chk("D_stall", 0, stall[0], 0);
    at_neg(c0 + 3); chk("D_no_ack", 0, if_ack[0], 0);
    #2; rst = 1'b0;
    drive_at(c0 + 5); if_req[0] = 1; if_addr[0] = 6'd5;
    at_neg(c0 + 7); chk("D_ack_early", 0, if_ack[0], 0);
    at_neg(c0 + 8);
    chk("D_if_ack", 0, if_ack[0], 1);
    chk("D_if_rdata", 0, if_rdata[0], 32'h00A0_0093);
    drive_at(c0 + 9); if_req[0] = 0;

    // Address change after grant is ignored.
    c0 = cyc + 2;
    drive_at(c0); if_req[0] = 1; if_addr[0] = 6'd7;
    drive_at(c0 + 1); if_addr[0] = 6'd5;
    at_neg(c0 + 1); chk("E_mem_addr", 0, mem_addr[0], 7);
    at_neg(c0 + 3); chk("E_if_rdata", 0, if_rdata[0], 32'h7777_0007);
    drive_at(c0 + 4); if_req[0] = 0;

    // MEM_LAT=3 fetch.
    c0 = cyc + 2;
    drive_at(c0); if_req[1] = 1; if_addr[1] = 6'd5;
    at_neg(c0 + 1); chk("F_mem_en", 1, mem_en[1], 1);
    at_neg(c0 + 2); chk("F_mem_en_off", 1, mem_en[1], 0);
    at_neg(c0 + 4); chk("F_ack_early", 1, if_ack[1], 0);
    at_neg(c0 + 5);
    chk("F_if_ack", 1, if_ack[1], 1);
    chk("F_if_rdata", 1, if_rdata[1], 32'h1122_3344);
    chk("F_stall", 1, stall[1], 5);
    drive_at(c0 + 6); if_req[1] = 0;

    // Fetch starved by a continuous data requester: counter saturates.
    c0 = cyc + 2;
    drive_at(c0);
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1; if_addr[k] = 6'd5; d_req[k] = 1; d_we[k] = 0; d_addr[k] = 6'd3;
    end
    at_neg(c0 + 65540);
    chk("G_sat", 0, stall[0], 16'hFFFF);
    chk("G_sat", 1, stall[1], 16'hFFFF);
    at_neg(c0 + 65560);
    chk("G_hold", 0, stall[0], 16'hFFFF);
    chk("G_hold", 1, stall[1], 16'hFFFF);
    drive_at(c0 + 65561);
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0; d_req[k] = 0;
    end
    at_neg(c0 + 65580);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
